// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the pipelined MIPS core.
// Captures the conunit control bundle and ID operands into EX, inserts
// bubbles on flush and on load-use hazards, and drives the upstream
// PC / IF-ID write enables.
// Optional feature macro: HAZARD_DETECT_EN (load-use detection and the
// bubble statistics counter). Without it, stall is tied low and software
// scheduling must cover load-use gaps.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [31:0]   id_inst,
    input  logic          id_reg_dst,
    input  logic          id_jump,
    input  logic          id_branch,
    input  logic          id_mem_read,
    input  logic          id_mem_to_reg,
    input  logic          id_mem_write,
    input  logic          id_alu_src,
    input  logic          id_reg_write,
    input  logic [1:0]    id_alu_op,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [5:0]    id_funct,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_pc_plus4,
    input  logic          flush,
    output logic          ex_reg_dst,
    output logic          ex_jump,
    output logic          ex_branch,
    output logic          ex_mem_read,
    output logic          ex_mem_to_reg,
    output logic          ex_mem_write,
    output logic          ex_alu_src,
    output logic          ex_reg_write,
    output logic [1:0]    ex_alu_op,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic [RW-1:0] ex_rd,
    output logic [5:0]    ex_funct,
    output logic [DW-1:0] ex_rd1,
    output logic [DW-1:0] ex_rd2,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc_plus4,
    output logic          ex_valid,
    output logic          pc_write,
    output logic          if_id_write,
    output logic          stall,
    output logic [CW-1:0] bubble_count
);

    logic bubble;
    logic load_use;

`ifdef HAZARD_DETECT_EN
    // Load in EX whose destination feeds the ID instruction; $0 never hazards.
    // A store reads rt as data even though alu_src selects the immediate.
    always_comb begin
        load_use = 1'b0;
        if (ex_mem_read && (ex_rt != '0)) begin
            if (ex_rt == id_rs) begin
                load_use = 1'b1;
            end else if ((ex_rt == id_rt) && (!id_alu_src || id_mem_write)) begin
                load_use = 1'b1;
            end
        end
    end

    // A redirect kills the ID instruction, so it cannot be waiting on a load.
    assign stall = load_use && !flush;
`else
    assign load_use = 1'b0;
    assign stall    = 1'b0;
`endif

    assign pc_write    = ~stall;
    assign if_id_write = ~stall;
    assign bubble      = flush || stall;

    // Control bundle: zeroed on a bubble; jumps never write memory or registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_reg_dst    <= 1'b0;
            ex_jump       <= 1'b0;
            ex_branch     <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_alu_op     <= 2'b00;
            ex_valid      <= 1'b0;
        end else if (bubble) begin
            ex_reg_dst    <= 1'b0;
            ex_jump       <= 1'b0;
            ex_branch     <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_alu_op     <= 2'b00;
            ex_valid      <= 1'b0;
        end else begin
            ex_reg_dst    <= id_reg_dst;
            ex_jump       <= id_jump;
            ex_branch     <= id_branch;
            ex_mem_read   <= id_mem_read;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_mem_write  <= id_jump ? 1'b0 : id_mem_write;
            ex_alu_src    <= id_alu_src;
            ex_reg_write  <= id_jump ? 1'b0 : id_reg_write;
            ex_alu_op     <= id_alu_op;
            ex_valid      <= (id_inst != 32'd0);
        end
    end

    // Data fields and specifiers only move on a real load; a bubble keeps them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_funct    <= '0;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm      <= '0;
            ex_pc_plus4 <= '0;
        end else if (!bubble) begin
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_funct    <= id_funct;
            ex_rd1      <= id_rd1;
            ex_rd2      <= id_rd2;
            ex_imm      <= id_imm;
            ex_pc_plus4 <= id_pc_plus4;
        end
    end

`ifdef HAZARD_DETECT_EN
    // Saturating count of load-use bubbles; flush bubbles are not counted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bubble_count <= '0;
        end else if (stall && (bubble_count != '1)) begin
            bubble_count <= bubble_count + {{(CW-1){1'b0}}, 1'b1};
        end
    end
`else
    assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
// Expectations follow HAZARD_DETECT_EN: with it undefined, stall never fires
// and bubble_count stays 0. The counter width is reduced so saturation is
// reachable in a short run.
module tb_id_ex_stage;

    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int TB_CW = 4;
`ifdef HAZARD_DETECT_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    // {reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}
    localparam logic [9:0] CTRL_R    = 10'b1000000110;
    localparam logic [9:0] CTRL_LW   = 10'b0001101100;
    localparam logic [9:0] CTRL_SW   = 10'b0000011000;
    localparam logic [9:0] CTRL_ADDI = 10'b0000001100;
    localparam logic [9:0] CTRL_J    = 10'b01000x0x00;
    localparam logic [9:0] CTRL_J_EX = 10'b0100000000;

    logic          clock;
    logic          reset_n;
    logic [31:0]   id_inst;
    logic          id_reg_dst, id_jump, id_branch, id_mem_read;
    logic          id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write;
    logic [1:0]    id_alu_op;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [5:0]    id_funct;
    logic [DW-1:0] id_rd1, id_rd2, id_imm, id_pc_plus4;
    logic          flush;
    logic          ex_reg_dst, ex_jump, ex_branch, ex_mem_read;
    logic          ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
    logic [1:0]    ex_alu_op;
    logic [RW-1:0] ex_rs, ex_rt, ex_rd;
    logic [5:0]    ex_funct;
    logic [DW-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc_plus4;
    logic          ex_valid, pc_write, if_id_write, stall;
    logic [TB_CW-1:0] bubble_count;
    logic [9:0]    ex_ctrl;

    int assert_count;
    int fail_count;
    int exp_bubbles;

    assign ex_ctrl = {ex_reg_dst, ex_jump, ex_branch, ex_mem_read, ex_mem_to_reg,
                      ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op};

    id_ex_stage #(.DW(DW), .RW(RW), .CW(TB_CW)) dut (
        .clock(clock), .reset_n(reset_n), .id_inst(id_inst),
        .id_reg_dst(id_reg_dst), .id_jump(id_jump), .id_branch(id_branch),
        .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_pc_plus4(id_pc_plus4), .flush(flush),
        .ex_reg_dst(ex_reg_dst), .ex_jump(ex_jump), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
        .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_pc_plus4(ex_pc_plus4), .ex_valid(ex_valid),
        .pc_write(pc_write), .if_id_write(if_id_write), .stall(stall),
        .bubble_count(bubble_count)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] inst, input logic [9:0] ctrl,
                                 input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                 input logic [RW-1:0] rd, input logic [5:0] funct,
                                 input logic [DW-1:0] rd1, input logic [DW-1:0] rd2,
                                 input logic [DW-1:0] imm, input logic [DW-1:0] pc4);
        id_inst = inst;
        {id_reg_dst, id_jump, id_branch, id_mem_read, id_mem_to_reg,
         id_mem_write, id_alu_src, id_reg_write, id_alu_op} = ctrl;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_funct    = funct;
        id_rd1      = rd1;
        id_rd2      = rd2;
        id_imm      = imm;
        id_pc_plus4 = pc4;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        exp_bubbles  = 0;
        reset_n      = 1'b0;
        flush        = 1'b0;
        applyStimulus(32'd0, 10'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // Reset state
        #12;
        $display("[TB] reset checks");
        checkOutput("reset_ctrl", 32'(ex_ctrl), 32'd0);
        checkOutput("reset_valid", 32'(ex_valid), 32'd0);
        checkOutput("reset_bubbles", 32'(bubble_count), 32'd0);
        reset_n = 1'b1;

        // R-type add $4,$2,$3
        applyStimulus(32'h00432020, CTRL_R, 5'd2, 5'd3, 5'd4, 6'h20,
                      32'd5, 32'd7, 32'h00002020, 32'h00000104);
        tick();
        checkOutput("add_ctrl", 32'(ex_ctrl), 32'(CTRL_R));
        checkOutput("add_rd1", ex_rd1, 32'd5);
        checkOutput("add_rd2", ex_rd2, 32'd7);
        checkOutput("add_rd", 32'(ex_rd), 32'd4);
        checkOutput("add_rs", 32'(ex_rs), 32'd2);
        checkOutput("add_funct", 32'(ex_funct), 32'h20);
        checkOutput("add_imm", ex_imm, 32'h00002020);
        checkOutput("add_pc4", ex_pc_plus4, 32'h00000104);
        checkOutput("add_valid", 32'(ex_valid), 32'd1);

        // Asynchronous reset in the middle of the cycle
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_ctrl", 32'(ex_ctrl), 32'd0);
        checkOutput("async_valid", 32'(ex_valid), 32'd0);
        checkOutput("async_rd1", ex_rd1, 32'd0);
        checkOutput("async_bubbles", 32'(bubble_count), 32'd0);
        #1;
        reset_n = 1'b1;

        // lw $8,0($1) then add $10,$8,$9: load-use hazard
        applyStimulus(32'h8C280000, CTRL_LW, 5'd1, 5'd8, 5'd0, 6'd0,
                      32'h1000, 32'h2000, 32'd0, 32'h108);
        tick();
        checkOutput("lw_ctrl", 32'(ex_ctrl), 32'(CTRL_LW));
        applyStimulus(32'h01095020, CTRL_R, 5'd8, 5'd9, 5'd10, 6'h20,
                      32'h11, 32'h22, 32'h00005020, 32'h10C);
        #1;
        checkOutput("lu_stall", 32'(stall), 32'(HZ));
        checkOutput("lu_pc_write", 32'(pc_write), 32'(!HZ));
        checkOutput("lu_if_id_write", 32'(if_id_write), 32'(!HZ));
        tick();
        if (HZ) exp_bubbles++;
        checkOutput("lu_bubble_valid", 32'(ex_valid), HZ ? 32'd0 : 32'd1);
        checkOutput("lu_bubble_ctrl", 32'(ex_ctrl), HZ ? 32'd0 : 32'(CTRL_R));
        checkOutput("lu_bubble_rd1", ex_rd1, HZ ? 32'h1000 : 32'h11);
        checkOutput("lu_count", 32'(bubble_count), 32'(exp_bubbles));
        checkOutput("lu_stall_drop", 32'(stall), 32'd0);
        if (HZ) tick();
        checkOutput("lu_add_ctrl", 32'(ex_ctrl), 32'(CTRL_R));
        checkOutput("lu_add_rd1", ex_rd1, 32'h11);
        checkOutput("lu_add_valid", 32'(ex_valid), 32'd1);

        // lw $8 then addi $8,$9,5: rt is a destination, no hazard
        applyStimulus(32'h8C280000, CTRL_LW, 5'd1, 5'd8, 5'd0, 6'd0,
                      32'h1000, 32'h2000, 32'd0, 32'h110);
        tick();
        applyStimulus(32'h21280005, CTRL_ADDI, 5'd9, 5'd8, 5'd0, 6'd5,
                      32'h33, 32'h44, 32'd5, 32'h114);
        #1;
        checkOutput("addi_stall", 32'(stall), 32'd0);
        checkOutput("addi_pc_write", 32'(pc_write), 32'd1);
        tick();
        checkOutput("addi_ctrl", 32'(ex_ctrl), 32'(CTRL_ADDI));
        checkOutput("addi_rt", 32'(ex_rt), 32'd8);

        // lw $0 then add $10,$0,$0: register $0 never hazards
        applyStimulus(32'h8C200000, CTRL_LW, 5'd1, 5'd0, 5'd0, 6'd0,
                      32'h1000, 32'd0, 32'd0, 32'h118);
        tick();
        applyStimulus(32'h00005020, CTRL_R, 5'd0, 5'd0, 5'd10, 6'h20,
                      32'd0, 32'd0, 32'h00005020, 32'h11C);
        #1;
        checkOutput("zero_stall", 32'(stall), 32'd0);
        tick();
        checkOutput("zero_ctrl", 32'(ex_ctrl), 32'(CTRL_R));

        // lw $8 then sw $8,4($1): store data operand hazards despite alu_src
        applyStimulus(32'h8C280000, CTRL_LW, 5'd1, 5'd8, 5'd0, 6'd0,
                      32'h1000, 32'h2000, 32'd0, 32'h120);
        tick();
        applyStimulus(32'hAC280004, CTRL_SW, 5'd1, 5'd8, 5'd0, 6'd4,
                      32'h55, 32'h66, 32'd4, 32'h124);
        #1;
        checkOutput("sw_stall", 32'(stall), 32'(HZ));
        tick();
        if (HZ) exp_bubbles++;
        checkOutput("sw_count", 32'(bubble_count), 32'(exp_bubbles));
        if (HZ) tick();
        checkOutput("sw_ctrl", 32'(ex_ctrl), 32'(CTRL_SW));

        // Flush while the hazard condition holds: flush wins, not counted
        applyStimulus(32'h8C280000, CTRL_LW, 5'd1, 5'd8, 5'd0, 6'd0,
                      32'h1000, 32'h2000, 32'd0, 32'h128);
        tick();
        applyStimulus(32'h01095020, CTRL_R, 5'd8, 5'd9, 5'd10, 6'h20,
                      32'h77, 32'h88, 32'h00005020, 32'h12C);
        flush = 1'b1;
        #1;
        checkOutput("flush_stall", 32'(stall), 32'd0);
        checkOutput("flush_pc_write", 32'(pc_write), 32'd1);
        checkOutput("flush_if_id_write", 32'(if_id_write), 32'd1);
        tick();
        flush = 1'b0;
        checkOutput("flush_ctrl", 32'(ex_ctrl), 32'd0);
        checkOutput("flush_valid", 32'(ex_valid), 32'd0);
        checkOutput("flush_rd1_held", ex_rd1, 32'h1000);
        checkOutput("flush_count", 32'(bubble_count), 32'(exp_bubbles));

        // Jump with don't-care write controls: writes are forced off
        applyStimulus(32'h08000040, CTRL_J, 5'd0, 5'd0, 5'd0, 6'h0,
                      32'd0, 32'd0, 32'h40, 32'h130);
        tick();
        checkOutput("jump_ctrl", 32'(ex_ctrl), 32'(CTRL_J_EX));
        checkOutput("jump_valid", 32'(ex_valid), 32'd1);

        // All-zero instruction is a NOP and never valid
        applyStimulus(32'd0, 10'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'h134);
        tick();
        checkOutput("nop_valid", 32'(ex_valid), 32'd0);

        // lw $8,0($8) held in ID: stalls every other cycle, counter saturates
        applyStimulus(32'h8D080000, CTRL_LW, 5'd8, 5'd8, 5'd0, 6'd0,
                      32'h1000, 32'd0, 32'd0, 32'h138);
        for (int i = 0; i < 20; i++) tick();
        if (HZ) exp_bubbles += 10;
        checkOutput("sat_mid_count", 32'(bubble_count), 32'(exp_bubbles));
        for (int i = 0; i < 20; i++) tick();
        checkOutput("sat_full_count", 32'(bubble_count), HZ ? 32'd15 : 32'd0);
        tick();
        checkOutput("sat_lw_ctrl", 32'(ex_ctrl), 32'(CTRL_LW));
        checkOutput("sat_stall", 32'(stall), 32'(HZ));
        tick();
        checkOutput("sat_hold_count", 32'(bubble_count), HZ ? 32'd15 : 32'd0);
        checkOutput("sat_valid", 32'(ex_valid), HZ ? 32'd0 : 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
